i2c_target_core: RTL

- Single-address I2C target (slave) engine: the responder for the team's I2C master core on the same open-drain bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs.
- Receives write bytes and serves read bytes through a byte-level handshake to the Avalon register wrapper.
- No clock stretching: SCL is input-only.

---
 rtl/i2c_target_core.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_core.sv
// -----------------------------------------------------------------------------
// i2c_target_core
//
// Single-address I2C target (slave) engine. SCL and SDA are oversampled on the
// system clock. The core detects START, repeated START and STOP, and matches a
// 7-bit address, which it ACKs. Write bytes are handed to the user through
// rx_data/rx_valid. Read bytes are requested with tx_req and taken from tx_data.
// SCL is input-only, so the core never stretches the clock.
//
// Optional feature (compile-time macro I2C_TARGET_GENERAL_CALL_EN):
//   defined   - address 7'h00 with rw=0 (general call) is also ACKed and the
//               bytes that follow are received as writes.
//   undefined - 7'h00 is treated like any other non-matching address.
//
// Parameters:
//   TARGET_ADDR  7-bit address this target answers to (default 7'h50)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   scl_i      in   raw SCL from pad
//   sda_i      in   raw SDA from pad
//   sda_o      out  open-drain SDA control (0 = pull low, 1 = release)
//   rx_data    out  last received write byte
//   rx_valid   out  one-clk pulse, rx_data updated
//   tx_data    in   next read byte, sampled only at the SCL fall that loads it
//   tx_req     out  one-clk pulse, tx_data must be valid before next SCL fall
//   rw         out  R/W bit of the current addressed transfer
//   addressed  out  high from address ACK until STOP, repeated START or NACK
//   start_det  out  one-clk pulse on START or repeated START
//   stop_det   out  one-clk pulse on STOP
// -----------------------------------------------------------------------------
module i2c_target_core #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       addressed,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6
    } state_t;

    // Synchronizer and history flops, reset to the idle-bus level.
    logic scl_meta_r, scl_sync_r, scl_hist_r;
    logic sda_meta_r, sda_sync_r, sda_hist_r;

    state_t     state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic [6:0] tx_shift_r;
    // Set on the 8th SCL rise of a byte. It tells the next fall apart from
    // the fall that follows START, because both see bit_cnt_r == 0.
    logic       byte_done_r;
    // Set when the master ACKs a read byte. The next fall then loads tx_data.
    logic       master_ack_r;

    logic scl_rise_s, scl_fall_s, start_s, stop_s;
    logic addr_match_s, gc_match_s, addr_ok_s;

    // Two-stage synchronizer plus one history stage on each bus line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
        end
    end

    // SCL edges, and SDA edges qualified by SCL being high in both samples.
    assign scl_rise_s = scl_sync_r & ~scl_hist_r;
    assign scl_fall_s = ~scl_sync_r & scl_hist_r;
    assign start_s    = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;

    // Address decode on the completed address byte.
    assign addr_match_s = (shift_r[7:1] == TARGET_ADDR);
`ifdef I2C_TARGET_GENERAL_CALL_EN
    assign gc_match_s   = (shift_r == 8'h00);
`else
    assign gc_match_s   = 1'b0;
`endif
    assign addr_ok_s    = addr_match_s | gc_match_s;

    // Protocol FSM. All outputs are registered here. Bus events take
    // priority over SCL edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            tx_shift_r   <= 7'h00;
            byte_done_r  <= 1'b0;
            master_ack_r <= 1'b0;
            sda_o        <= 1'b1;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            tx_req       <= 1'b0;
            rw           <= 1'b0;
            addressed    <= 1'b0;
            start_det    <= 1'b0;
            stop_det     <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;

            if (start_s) begin
                state_r      <= ADDR;
                bit_cnt_r    <= 3'd0;
                byte_done_r  <= 1'b0;
                master_ack_r <= 1'b0;
                sda_o        <= 1'b1;
                addressed    <= 1'b0;
                start_det    <= 1'b1;
            end else if (stop_s) begin
                state_r      <= IDLE;
                bit_cnt_r    <= 3'd0;
                byte_done_r  <= 1'b0;
                master_ack_r <= 1'b0;
                sda_o        <= 1'b1;
                addressed    <= 1'b0;
                stop_det     <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        sda_o <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_sync_r};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                byte_done_r <= 1'b1;
                            end
                        end else if (scl_fall_s && byte_done_r) begin
                            byte_done_r <= 1'b0;
                            if (addr_ok_s) begin
                                sda_o     <= 1'b0;
                                rw        <= shift_r[0];
                                addressed <= 1'b1;
                                tx_req    <= shift_r[0];
                                state_r   <= ADDR_ACK;
                            end else begin
                                sda_o   <= 1'b1;
                                state_r <= IDLE;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall_s) begin
                            bit_cnt_r <= 3'd0;
                            if (rw) begin
                                sda_o      <= tx_data[7];
                                tx_shift_r <= tx_data[6:0];
                                state_r    <= TX;
                            end else begin
                                sda_o   <= 1'b1;
                                state_r <= RX;
                            end
                        end
                    end

                    RX: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[6:0], sda_sync_r};
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                rx_data     <= {shift_r[6:0], sda_sync_r};
                                rx_valid    <= 1'b1;
                                byte_done_r <= 1'b1;
                            end
                        end else if (scl_fall_s && byte_done_r) begin
                            byte_done_r <= 1'b0;
                            sda_o       <= 1'b0;
                            state_r     <= RX_ACK;
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall_s) begin
                            sda_o     <= 1'b1;
                            bit_cnt_r <= 3'd0;
                            state_r   <= RX;
                        end
                    end

                    TX: begin
                        if (scl_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                byte_done_r <= 1'b1;
                            end
                        end else if (scl_fall_s) begin
                            if (byte_done_r) begin
                                byte_done_r <= 1'b0;
                                sda_o       <= 1'b1;
                                state_r     <= TX_ACK;
                            end else begin
                                sda_o      <= tx_shift_r[6];
                                tx_shift_r <= {tx_shift_r[5:0], 1'b0};
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_sync_r) begin
                                master_ack_r <= 1'b1;
                                tx_req       <= 1'b1;
                            end else begin
                                addressed <= 1'b0;
                                sda_o     <= 1'b1;
                                state_r   <= IDLE;
                            end
                        end else if (scl_fall_s && master_ack_r) begin
                            master_ack_r <= 1'b0;
                            bit_cnt_r    <= 3'd0;
                            sda_o        <= tx_data[7];
                            tx_shift_r   <= tx_data[6:0];
                            state_r      <= TX;
                        end
                    end

                    default: begin
                        sda_o     <= 1'b1;
                        addressed <= 1'b0;
                        state_r   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
